pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: jumps, multi-cycle ops, load-use stalls.
// Latency: control outputs are combinational from state+inputs; state/counters update next edge.
// Backpressure: holds PC and IF/ID while a stall or multi-cycle op is pending; ERR holds forever.
module pipe_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int FLUSH_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        mc_start_i,
  input  logic        mc_done_i,
  input  logic        ex_is_load_i,
  input  logic        ex_rd_write_en_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  output logic        pc_hold_o,
  output logic        pc_load_o,
  output logic [31:0] pc_load_addr_o,
  output logic        if_id_hold_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        err_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MC_WAIT = 2'd2,
    ST_ERR     = 2'd3
  } state_t;

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic [FW-1:0] flush_step;

  logic hazard;
  logic pc_hold_c, pc_load_c, if_id_hold_c, if_id_flush_c, id_ex_flush_c;

  // Load-use: a load in EX writing a non-zero register that decode is about to read.
  assign hazard = ex_is_load_i && ex_rd_write_en_i && (ex_rd_addr_i != 5'd0) &&
                  ((ex_rd_addr_i == id_rs1_addr_i) || (ex_rd_addr_i == id_rs2_addr_i));

  // Per-state control decode; in RUN a jump beats mc_start, which beats a hazard.
  always_comb begin
    pc_hold_c     = 1'b0;
    pc_load_c     = 1'b0;
    if_id_hold_c  = 1'b0;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    case (state)
      ST_RUN: begin
        if (jump_en_i) begin
          pc_load_c     = 1'b1;
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
        end else if (mc_start_i) begin
          pc_hold_c    = 1'b1;
          if_id_hold_c = 1'b1;
        end else if (hazard) begin
          pc_hold_c     = 1'b1;
          if_id_hold_c  = 1'b1;
          id_ex_flush_c = 1'b1;
        end
      end
      ST_FLUSH: begin
        if_id_flush_c = 1'b1;
        id_ex_flush_c = 1'b1;
      end
      ST_MC_WAIT: begin
        if (!mc_done_i) begin
          pc_hold_c     = 1'b1;
          if_id_hold_c  = 1'b1;
          id_ex_flush_c = 1'b1;
        end
      end
      default: begin
        pc_hold_c     = 1'b1;
        if_id_hold_c  = 1'b1;
        id_ex_flush_c = 1'b1;
      end
    endcase
  end

  // Outputs are gated by rst_n so input-driven paths stay quiet while reset is held.
  assign pc_hold_o      = rst_n & pc_hold_c;
  assign pc_load_o      = rst_n & pc_load_c;
  assign pc_load_addr_o = (rst_n && pc_load_c) ? jump_addr_i : 32'd0;
  assign if_id_hold_o   = rst_n & if_id_hold_c;
  assign if_id_flush_o  = rst_n & if_id_flush_c;
  assign id_ex_flush_o  = rst_n & id_ex_flush_c;
  assign err_o          = rst_n & (state == ST_ERR);

  // State machine, flush/timeout sequencing and saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      tmo_cnt     <= '0;
      flush_step  <= '0;
      stall_cnt_o <= 16'd0;
      flush_cnt_o <= 16'd0;
    end else begin
      case (state)
        ST_RUN: begin
          if (jump_en_i) begin
            state      <= ST_FLUSH;
            flush_step <= '0;
            if (flush_cnt_o != 16'hFFFF) flush_cnt_o <= flush_cnt_o + 16'd1;
          end else if (mc_start_i) begin
            state   <= ST_MC_WAIT;
            tmo_cnt <= '0;
          end else if (hazard) begin
            if (stall_cnt_o != 16'hFFFF) stall_cnt_o <= stall_cnt_o + 16'd1;
          end
        end
        ST_FLUSH: begin
          if (flush_step == FLUSH_LAST) state <= ST_RUN;
          else flush_step <= flush_step + 1'b1;
        end
        ST_MC_WAIT: begin
          // A done arriving on the final allowed cycle still wins over the timeout.
          if (mc_done_i) state <= ST_RUN;
          else if (tmo_cnt == TMO_LAST) state <= ST_ERR;
          else tmo_cnt <= tmo_cnt + 1'b1;
        end
        default: state <= ST_ERR;
      endcase
    end
  end

endmodule
